// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader that writes instruction memory and holds the core until a verified load
module imem_loader #(
  parameter int MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic [7:0]  Byte_in,
  input  logic        Byte_valid,
  output logic        Byte_ready,
  output logic        Mem_wr_en,
  output logic [31:0] Mem_wr_addr,
  output logic [31:0] Mem_wr_data,
  output logic        Cpu_hold,
  output logic        Done,
  output logic        Error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  localparam logic [15:0] MAX_WORDS = 16'(MEM_BYTES / 4);

  state_t      state, state_n;
  logic [7:0]  n_lo;
  logic [15:0] n_words;
  logic [15:0] word_idx;
  logic [1:0]  byte_cnt;
  logic [7:0]  csum;
  logic [31:0] word_sr;
  logic        take;
  logic [15:0] n_in;

  // Byte_ready is a registered copy of "state accepts a byte", so it is a valid handshake term.
  assign take = Byte_valid && Byte_ready;
  assign n_in = {Byte_in, n_lo};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state logic for the frame parser.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (Start) state_n = S_LEN0;
      S_LEN0:  if (take) state_n = S_LEN1;
      S_LEN1: begin
        if (take) begin
          if (n_in > MAX_WORDS)   state_n = S_ERR;
          else if (n_in == 16'd0) state_n = S_CHK;
          else                    state_n = S_DATA;
        end
      end
      S_DATA:  if (take && byte_cnt == 2'd3) state_n = S_WRITE;
      S_WRITE: state_n = (word_idx + 16'd1 == n_words) ? S_CHK : S_DATA;
      S_CHK:   if (take) state_n = (Byte_in == csum) ? S_DONE : S_ERR;
      S_DONE:  if (Start) state_n = S_LEN0;
      S_ERR:   state_n = S_ERR;
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath: length capture, little-endian word assembly, running checksum, word index.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_lo     <= 8'd0;
      n_words  <= 16'd0;
      word_idx <= 16'd0;
      byte_cnt <= 2'd0;
      csum     <= 8'd0;
      word_sr  <= 32'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // Clearing here keeps the checksum at zero for an empty (N == 0) frame.
          if (Start) begin
            word_idx <= 16'd0;
            byte_cnt <= 2'd0;
            csum     <= 8'd0;
          end
        end
        S_LEN0: if (take) n_lo <= Byte_in;
        S_LEN1: begin
          if (take) begin
            n_words  <= n_in;
            word_idx <= 16'd0;
            byte_cnt <= 2'd0;
            csum     <= 8'd0;
          end
        end
        S_DATA: begin
          if (take) begin
            word_sr  <= {Byte_in, word_sr[31:8]};
            csum     <= csum ^ Byte_in;
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        S_WRITE: word_idx <= word_idx + 16'd1;
        default: ;
      endcase
    end
  end

  // Registered outputs, decoded from the state being entered so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      Byte_ready  <= 1'b0;
      Mem_wr_en   <= 1'b0;
      Mem_wr_addr <= 32'd0;
      Mem_wr_data <= 32'd0;
      Cpu_hold    <= 1'b1;
      Done        <= 1'b0;
      Error       <= 1'b0;
    end else begin
      Byte_ready <= (state_n == S_LEN0) || (state_n == S_LEN1) ||
                    (state_n == S_DATA) || (state_n == S_CHK);
      Mem_wr_en  <= (state_n == S_WRITE);
      Cpu_hold   <= (state_n != S_DONE);
      Done       <= (state_n == S_DONE);
      Error      <= (state_n == S_ERR);
      if (state == S_DATA && state_n == S_WRITE) begin
        Mem_wr_addr <= {14'b0, word_idx, 2'b00};
        Mem_wr_data <= {Byte_in, word_sr[31:8]};
      end
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes the instruction memory from a byte stream before the core runs. It accepts a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and issues one word write per assembled word. It holds the core in reset until a checksum-verified load completes. It sits between the host byte source and the instruction memory's write side; the core's fetch port reads what this block wrote.

## Interface
- MEM_BYTES, 256: instruction memory size in bytes; the maximum word count is MEM_BYTES/4.
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
- Byte_in  input  8  stream byte.
- Byte_valid  input  1  Byte_in is valid.
- Byte_ready  output  1  loader accepts a byte this cycle.
- Mem_wr_en  output  1  one-cycle word write strobe.
- Mem_wr_addr  output  32  byte address of the word being written, always a multiple of 4.
- Mem_wr_data  output  32  word being written; byte 0 of the stream word is in bits [7:0].
- Cpu_hold  output  1  holds the core in reset while high.
- Done  output  1  load completed and checksum matched.
- Error  output  1  load aborted; sticky until rst.

## Operation
- Frame format, in stream order:
  - N_lo, N_hi: 16-bit word count N, little-endian.
  - 4·N data bytes, least significant byte of each word first (mem[A]=bits[7:0], mem[A+3]=bits[31:24]).
  - One checksum byte equal to the XOR of all data bytes (length bytes excluded).
- A byte transfers on a rising edge where Byte_valid && Byte_ready. When Byte_valid is high and Byte_ready is low, nothing happens; the source must hold the byte.
- States and transitions:
  - IDLE: reset state. On Start, go to LEN0.
  - LEN0: take N_lo, then go to LEN1.
  - LEN1: take N_hi.
    - If N > MEM_BYTES/4, go to ERR.
    - If N == 0, go to CHK.
    - Otherwise clear the word index, byte count and checksum, then go to DATA.
  - DATA: take bytes into the word shift register. XOR each byte into the running checksum. The 4th byte goes to WRITE.
  - WRITE: lasts exactly one cycle.
    - Mem_wr_en=1, Mem_wr_addr=4·word_idx, Mem_wr_data=assembled word.
    - Increment word_idx. If word_idx+1 == N, go to CHK; else go to DATA.
  - CHK: take one byte. If it equals the running checksum, go to DONE; else go to ERR.
  - DONE: Done=1, Cpu_hold=0. On Start, go to LEN0: Done goes to 0 and Cpu_hold to 1 at the same edge.
  - ERR: Error=1, Cpu_hold=1. Start is ignored; only rst leaves ERR.
- Byte_ready=1 exactly in LEN0, LEN1, DATA and CHK; it is 0 in IDLE, WRITE, DONE and ERR.
- Start is ignored in every state except IDLE and DONE.
- Cpu_hold=1 in every state except DONE.
- Words already written before an error are not rolled back.
- Width rules:
  - N is 16 bits; word_idx is 16 bits.
  - Mem_wr_addr = {14'b0, word_idx, 2'b00}.
  - The comparison against MEM_BYTES/4 is unsigned.

## Timing
- All outputs are registered.
- Reset values: state IDLE, Byte_ready=0, Mem_wr_en=0, Mem_wr_addr=0, Mem_wr_data=0, Cpu_hold=1, Done=0, Error=0.
- rst has priority over every other input, including in the middle of a load. It returns the block to IDLE with the reset values above on the next edge. Partially written memory is left as is.
- Start is sampled at edge t; Byte_ready=1 from cycle t+1.
- The 4th data byte is accepted at edge t:
  - Mem_wr_en is high in cycle t+1 only, with the address and data valid in that same cycle.
  - Byte_ready=0 in cycle t+1 and returns to 1 in cycle t+2.
- Back-to-back throughput is 4 bytes per 5 cycles.
- N_hi is accepted at edge t: the ERR or CHK/DATA state is visible in cycle t+1.
- The checksum byte is accepted at edge t: Done or Error is high from cycle t+1, and Cpu_hold falls in cycle t+1 on success.
- The minimum load is Start followed by 00 00 00, giving Done 4 cycles after Start is sampled.

## Test plan
- Two-word load: Start, then bytes 02 00 13 00 00 00 93 00 10 00 90.
  - Expect exactly two writes: addr 0x0 with data 0x00000013, then addr 0x4 with data 0x00100093.
  - Then Done=1, Cpu_hold=0, Error=0.
- Empty load: Start, then bytes 00 00 00. Expect no Mem_wr_en, and Done=1 4 cycles after Start.
- Oversize: with MEM_BYTES=256, send bytes 41 00 (N=65).
  - Expect Error=1 and Byte_ready=0 the cycle after the second byte.
  - Expect no writes, Cpu_hold=1, and a later Start has no effect.
- Bad checksum: the stream from the two-word load test with a final byte of 91.
  - Expect both writes to still occur, then Error=1, Done=0, Cpu_hold=1.
- Backpressure and gaps: the two-word stream with Byte_valid dropped for 1–3 random cycles between bytes.
  - Expect identical writes and Done.
  - Expect Byte_ready=0 in each WRITE cycle, and a held byte not consumed twice.
- Reset mid-load: assert rst for one cycle after the 6th byte.
  - Expect all outputs at reset values and no further writes.
  - A following full two-word load then succeeds. A Start in DONE reloads, with Done falling and Cpu_hold rising at the same edge.
